// File: rtl/demux_pkg.sv
// Purpose: shared constants and helpers for the 1-to-2 stream demultiplexer.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package demux_pkg;

    localparam int DEMUX_DEPTH     = 2;
    localparam int DEMUX_FILL_W    = 2;
    localparam int DEMUX_CNT_W     = 16;
    localparam int DEMUX_WIDTH_DEF = 8;

    // A channel buffer is full once it holds DEMUX_DEPTH words.
    function automatic logic fill_is_full(input logic [DEMUX_FILL_W-1:0] fill);
        return fill == DEMUX_FILL_W'(DEMUX_DEPTH);
    endfunction

endpackage

// File: rtl/demux_fifo2.sv
// Purpose: 2-entry FIFO holding the words bound for one demux output channel.
// Latency: a pushed word is the head in the cycle after the push edge when the FIFO was empty.
// Backpressure: pushes at fill 2 and pops at fill 0 are ignored; the caller gates them.
module demux_fifo2
    import demux_pkg::*;
#(
    parameter int WIDTH = DEMUX_WIDTH_DEF
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    i_push,
    input  logic [WIDTH-1:0]        i_push_dat,
    input  logic                    i_pop,
    output logic [DEMUX_FILL_W-1:0] o_fill,
    output logic [WIDTH-1:0]        o_head
);

    // Head and tail are kept as a 2-deep shift register: the head register is
    // the output, so it only changes on a pop or on a push into an empty FIFO.
    // After the last pop it simply keeps the popped word.
    logic [WIDTH-1:0]        r_head;
    logic [WIDTH-1:0]        r_tail;
    logic [DEMUX_FILL_W-1:0] r_fill;
    logic                    w_push;
    logic                    w_pop;

    // Qualify requests against the current fill so the storage never overruns.
    always_comb begin
        w_push = i_push && !fill_is_full(r_fill);
        w_pop  = i_pop && (r_fill != '0);
    end

    // Fill counter and entry storage; cleared asynchronously on reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_fill <= '0;
            r_head <= '0;
            r_tail <= '0;
        end else begin
            case ({w_push, w_pop})
                2'b10: begin
                    if (r_fill == '0) begin
                        r_head <= i_push_dat;
                    end else begin
                        r_tail <= i_push_dat;
                    end
                    r_fill <= r_fill + 1'b1;
                end
                2'b01: begin
                    if (fill_is_full(r_fill)) begin
                        r_head <= r_tail;
                    end
                    r_fill <= r_fill - 1'b1;
                end
                2'b11: begin
                    // Simultaneous push and pop: fill is unchanged, entries shift.
                    if (fill_is_full(r_fill)) begin
                        r_head <= r_tail;
                        r_tail <= i_push_dat;
                    end else begin
                        r_head <= i_push_dat;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign o_fill = r_fill;
    assign o_head = r_head;

endmodule

// File: rtl/demux_1to2_stream.sv
// Purpose: registered 1-to-2 stream demux; in_sel steers each word to out0 or out1 (optional transfer counters with DEMUX_STATS_EN).
// Latency: 1 cycle from input accept edge to outN_valid/outN_data.
// Backpressure: in_ready drops only when the selected channel holds 2 words; never depends on outN_ready.
module demux_1to2_stream
    import demux_pkg::*;
#(
    parameter int WIDTH = DEMUX_WIDTH_DEF
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [WIDTH-1:0]       in_data,
    input  logic                   in_sel,
    input  logic                   in_valid,
    output logic                   in_ready,
    output logic [WIDTH-1:0]       out0_data,
    output logic                   out0_valid,
    input  logic                   out0_ready,
    output logic [WIDTH-1:0]       out1_data,
    output logic                   out1_valid,
    input  logic                   out1_ready
`ifdef DEMUX_STATS_EN
    ,
    output logic [DEMUX_CNT_W-1:0] out0_count,
    output logic [DEMUX_CNT_W-1:0] out1_count
`endif
);

    logic [DEMUX_FILL_W-1:0] w_fill0;
    logic [DEMUX_FILL_W-1:0] w_fill1;
    logic                    w_push0;
    logic                    w_push1;
    logic                    w_pop0;
    logic                    w_pop1;

    // Ready looks only at the registered fill of the selected channel, so a
    // stalled consumer on one side never blocks words bound for the other.
    always_comb begin
        in_ready = in_sel ? !fill_is_full(w_fill1) : !fill_is_full(w_fill0);
        w_push0  = in_valid && in_ready && !in_sel;
        w_push1  = in_valid && in_ready && in_sel;
        w_pop0   = out0_valid && out0_ready;
        w_pop1   = out1_valid && out1_ready;
    end

    demux_fifo2 #(.WIDTH(WIDTH)) u_fifo0 (
        .clk        (clk),
        .rst        (rst),
        .i_push     (w_push0),
        .i_push_dat (in_data),
        .i_pop      (w_pop0),
        .o_fill     (w_fill0),
        .o_head     (out0_data)
    );

    demux_fifo2 #(.WIDTH(WIDTH)) u_fifo1 (
        .clk        (clk),
        .rst        (rst),
        .i_push     (w_push1),
        .i_push_dat (in_data),
        .i_pop      (w_pop1),
        .o_fill     (w_fill1),
        .o_head     (out1_data)
    );

    assign out0_valid = (w_fill0 != '0);
    assign out1_valid = (w_fill1 != '0);

`ifdef DEMUX_STATS_EN
    logic [DEMUX_CNT_W-1:0] r_cnt0;
    logic [DEMUX_CNT_W-1:0] r_cnt1;

    // Per-channel output transfer counters, wrapping at 2^16.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt0 <= '0;
            r_cnt1 <= '0;
        end else begin
            if (w_pop0) begin
                r_cnt0 <= r_cnt0 + 1'b1;
            end
            if (w_pop1) begin
                r_cnt1 <= r_cnt1 + 1'b1;
            end
        end
    end

    assign out0_count = r_cnt0;
    assign out1_count = r_cnt1;
`endif

endmodule

// File: tb/tb_demux_1to2_stream.sv
// Purpose: self-checking bench for demux_1to2_stream (directed table, async reset, random vs queue model, optional counters).
// Latency: inputs driven on the falling edge, outputs sampled 1 time unit later, model advanced at the rising edge.
// Backpressure: random ready on both consumers exercises full/stalled channels.
module tb_demux_1to2_stream;

    localparam logic H = 1'b1;
    localparam logic L = 1'b0;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] in_data = 8'h00;
    logic       in_sel = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] out0_data;
    logic       out0_valid;
    logic       out0_ready = 1'b0;
    logic [7:0] out1_data;
    logic       out1_valid;
    logic       out1_ready = 1'b0;
`ifdef DEMUX_STATS_EN
    logic [15:0] out0_count;
    logic [15:0] out1_count;
`endif

    int total = 0;
    int bad   = 0;

    demux_1to2_stream #(.WIDTH(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_data    (in_data),
        .in_sel     (in_sel),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .out0_data  (out0_data),
        .out0_valid (out0_valid),
        .out0_ready (out0_ready),
        .out1_data  (out1_data),
        .out1_valid (out1_valid),
        .out1_ready (out1_ready)
`ifdef DEMUX_STATS_EN
        ,
        .out0_count (out0_count),
        .out1_count (out1_count)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       vld;
        logic       sel;
        logic [7:0] dat;
        logic       r0;
        logic       r1;
        logic       e_rdy;
        logic       e_v0;
        logic [7:0] e_d0;
        logic       e_v1;
        logic [7:0] e_d1;
    } vec_t;

    vec_t tbl[13];

    // Reference model: one queue per channel plus the last word popped from each.
    logic [7:0] q0[$];
    logic [7:0] q1[$];
    logic [7:0] last0;
    logic [7:0] last1;

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic drive(input logic vld, input logic sel, input logic [7:0] dat,
                         input logic r0, input logic r1);
        @(negedge clk);
        in_valid   = vld;
        in_sel     = sel;
        in_data    = dat;
        out0_ready = r0;
        out1_ready = r1;
        #1;
    endtask

    task automatic model_reset();
        q0.delete();
        q1.delete();
        last0 = 8'h00;
        last1 = 8'h00;
    endtask

    // One random cycle: compare against the queues, then apply the transfers.
    task automatic model_cycle(input string tag);
        logic vld, sel, r0, r1, rdy, pop0, pop1;
        logic [7:0] dat;
        vld = 1'($urandom_range(0, 1));
        sel = 1'($urandom_range(0, 1));
        dat = 8'($urandom);
        r0  = ($urandom_range(0, 3) != 0);
        r1  = ($urandom_range(0, 2) == 0);
        drive(vld, sel, dat, r0, r1);
        rdy = sel ? (q1.size() < 2) : (q0.size() < 2);
        chk({tag, "_in_ready"}, 16'(in_ready), 16'(rdy));
        chk({tag, "_v0"}, 16'(out0_valid), 16'(q0.size() != 0));
        chk({tag, "_v1"}, 16'(out1_valid), 16'(q1.size() != 0));
        chk({tag, "_d0"}, 16'(out0_data), 16'((q0.size() != 0) ? q0[0] : last0));
        chk({tag, "_d1"}, 16'(out1_data), 16'((q1.size() != 0) ? q1[0] : last1));
        pop0 = (q0.size() != 0) && r0;
        pop1 = (q1.size() != 0) && r1;
        @(posedge clk);
        if (pop0) last0 = q0.pop_front();
        if (pop1) last1 = q1.pop_front();
        if (vld && rdy) begin
            if (sel) q1.push_back(dat);
            else     q0.push_back(dat);
        end
    endtask

    initial begin
        #1500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Directed sequence: first push, push+pop at fill 1, channel 1 fill/stall,
        // no head-of-line blocking on channel 0, ready rising after the pop edge.
        tbl[0]  = '{L, L, 8'h00, H, L, H, L, 8'h00, L, 8'h00};
        tbl[1]  = '{H, L, 8'hA5, H, L, H, L, 8'h00, L, 8'h00};
        tbl[2]  = '{L, L, 8'h00, L, L, H, H, 8'hA5, L, 8'h00};
        tbl[3]  = '{H, L, 8'h55, H, L, H, H, 8'hA5, L, 8'h00};
        tbl[4]  = '{L, L, 8'h00, H, L, H, H, 8'h55, L, 8'h00};
        tbl[5]  = '{H, H, 8'h11, L, L, H, L, 8'h55, L, 8'h00};
        tbl[6]  = '{H, H, 8'h22, L, L, H, L, 8'h55, H, 8'h11};
        tbl[7]  = '{H, H, 8'h33, L, L, L, L, 8'h55, H, 8'h11};
        tbl[8]  = '{H, L, 8'h44, L, L, H, L, 8'h55, H, 8'h11};
        tbl[9]  = '{H, H, 8'h33, L, H, L, H, 8'h44, H, 8'h11};
        tbl[10] = '{H, H, 8'h33, L, H, H, H, 8'h44, H, 8'h22};
        tbl[11] = '{L, H, 8'h00, H, H, H, H, 8'h44, H, 8'h33};
        tbl[12] = '{L, L, 8'h00, L, L, H, L, 8'h44, L, 8'h33};

        // Initial reset.
        #1;
        chk("rst_v0", 16'(out0_valid), 16'h0);
        chk("rst_v1", 16'(out1_valid), 16'h0);
        chk("rst_d0", 16'(out0_data), 16'h0);
        chk("rst_d1", 16'(out1_data), 16'h0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 13; i++) begin
            drive(tbl[i].vld, tbl[i].sel, tbl[i].dat, tbl[i].r0, tbl[i].r1);
            chk($sformatf("tbl%0d_in_ready", i), 16'(in_ready), 16'(tbl[i].e_rdy));
            chk($sformatf("tbl%0d_v0", i), 16'(out0_valid), 16'(tbl[i].e_v0));
            chk($sformatf("tbl%0d_d0", i), 16'(out0_data), 16'(tbl[i].e_d0));
            chk($sformatf("tbl%0d_v1", i), 16'(out1_valid), 16'(tbl[i].e_v1));
            chk($sformatf("tbl%0d_d1", i), 16'(out1_data), 16'(tbl[i].e_d1));
        end

        // Fill both channels to 2 with consumers stalled, then reset asynchronously.
        drive(H, L, 8'hC1, L, L);
        drive(H, L, 8'hC2, L, L);
        drive(H, H, 8'hD1, L, L);
        drive(H, H, 8'hD2, L, L);
        drive(H, L, 8'hEE, L, L);
        chk("full0_in_ready", 16'(in_ready), 16'h0);
        in_sel = 1'b1;
        #1;
        chk("full1_in_ready", 16'(in_ready), 16'h0);
        chk("full_d0", 16'(out0_data), 16'hC1);
        chk("full_d1", 16'(out1_data), 16'hD1);
        rst = 1'b1;
        #1;
        chk("arst_v0", 16'(out0_valid), 16'h0);
        chk("arst_v1", 16'(out1_valid), 16'h0);
        chk("arst_d0", 16'(out0_data), 16'h0);
        chk("arst_d1", 16'(out1_data), 16'h0);
        chk("arst_in_ready", 16'(in_ready), 16'h1);
        // Keep valid high across a rising edge in reset: nothing may be accepted.
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        in_valid = 1'b0;
        #1;
        chk("post_rst_in_ready", 16'(in_ready), 16'h1);
        chk("post_rst_v0", 16'(out0_valid), 16'h0);
        chk("post_rst_v1", 16'(out1_valid), 16'h0);
        chk("post_rst_d0", 16'(out0_data), 16'h0);
        chk("post_rst_d1", 16'(out1_data), 16'h0);

        // Random traffic against the queue model.
        model_reset();
        for (int i = 0; i < 10000; i++) begin
            model_cycle("rnd");
        end

`ifdef DEMUX_STATS_EN
        // Counter wrap: 65537 transfers on channel 0 only.
        drive(L, L, 8'h00, L, L);
        rst = 1'b1;
        #1;
        rst = 1'b0;
        #1;
        chk("cnt_rst0", out0_count, 16'h0);
        chk("cnt_rst1", out1_count, 16'h0);
        begin
            int pops;
            int cyc;
            pops = 0;
            cyc  = 0;
            while (pops < 65537 && cyc < 70000) begin
                drive(H, L, 8'(cyc), H, L);
                if (out0_valid) pops++;
                cyc++;
                @(posedge clk);
            end
            chk("cnt_budget", 16'(pops == 65537), 16'h1);
        end
        drive(L, L, 8'h00, L, L);
        chk("cnt_wrap0", out0_count, 16'h1);
        chk("cnt_wrap1", out1_count, 16'h0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
